// File: rtl/vbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vbank_pkg
// Description : Shared default widths and request record for the vbank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vbank_pkg;

    localparam int VB_NUM_REQ      = 4;
    localparam int VB_INDEX_WIDTH  = 8;
    localparam int VB_NUM_ELEMENTS = 32;
    localparam int VB_DATA_WIDTH   = 16;
    localparam int VB_ROW_WIDTH    = VB_NUM_ELEMENTS * VB_DATA_WIDTH;

    typedef struct packed {
        logic                       wr;
        logic [VB_INDEX_WIDTH-1:0]  addr;
        logic [VB_ROW_WIDTH-1:0]    wdata;
        logic [VB_NUM_ELEMENTS-1:0] wstrb;
    } vb_req_t;

endpackage : vbank_pkg
`default_nettype wire

// File: rtl/vbank_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : vbank_arb_if
// Description : Requester-side and bank-side bundle of the vbank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vbank_arb_if
    import vbank_pkg::*;
#(
    parameter int NUM_REQ      = VB_NUM_REQ,
    parameter int INDEX_WIDTH  = VB_INDEX_WIDTH,
    parameter int NUM_ELEMENTS = VB_NUM_ELEMENTS,
    parameter int DATA_WIDTH   = VB_DATA_WIDTH
) ();
    localparam int ROW_W = NUM_ELEMENTS * DATA_WIDTH;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              req_wr;
    logic [NUM_REQ*INDEX_WIDTH-1:0]  req_addr;
    logic [NUM_REQ*ROW_W-1:0]        req_wdata;
    logic [NUM_REQ*NUM_ELEMENTS-1:0] req_wstrb;
    logic [NUM_REQ-1:0]              resp_valid;
    logic [ROW_W-1:0]                resp_rdata;

    logic                            ren;
    logic [INDEX_WIDTH-1:0]          raddr;
    logic                            wen;
    logic [INDEX_WIDTH-1:0]          waddr;
    logic [ROW_W-1:0]                wdata;
    logic [NUM_ELEMENTS-1:0]         wstrb;
    logic [ROW_W-1:0]                rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_wstrb, rdata,
        input  req_ready, resp_valid, resp_rdata, ren, raddr, wen, waddr, wdata, wstrb
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_wstrb, rdata,
        output req_ready, resp_valid, resp_rdata, ren, raddr, wen, waddr, wdata, wstrb
    );

endinterface : vbank_arb_if
`default_nettype wire

// File: rtl/vbank_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter, one-hot combinational grant, pointer moves
//               to winner+1 only when a grant issues.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_id,
    output logic               o_any
);
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_id;
    logic               w_any;
    int                 w_idx;

    always_comb begin
        w_grant = '0;
        w_id    = '0;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_any && i_req[PTR_W'(w_idx)]) begin
                w_grant[PTR_W'(w_idx)] = 1'b1;
                w_id                   = PTR_W'(w_idx);
                w_any                  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (int'(w_id) == NUM_REQ - 1) ? '0 : w_id + PTR_W'(1);
        end
    end

    assign o_grant = w_grant;
    assign o_id    = w_id;
    assign o_any   = w_any;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/vbank_arb.sv
`default_nettype none
// ============================================================================
// Module      : vbank_arb
// Description : Independent read/write round-robin arbitration of NUM_REQ
//               requesters onto one vbank; 1-cycle read response.
//               Optional macro VBANK_ARB_RAW_FWD_EN forwards same-cycle writes.
// Revision    : 1.0 - initial release
// ============================================================================
module vbank_arb
    import vbank_pkg::*;
#(
    parameter int NUM_REQ      = VB_NUM_REQ,
    parameter int INDEX_WIDTH  = VB_INDEX_WIDTH,
    parameter int NUM_ELEMENTS = VB_NUM_ELEMENTS,
    parameter int DATA_WIDTH   = VB_DATA_WIDTH
) (
    input  logic        clk,
    input  logic        nRST,
    vbank_arb_if.slave  bus
);
    localparam int ROW_W = NUM_ELEMENTS * DATA_WIDTH;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      w_rd_req,   w_wr_req;
    logic [NUM_REQ-1:0]      w_rd_grant, w_wr_grant;
    logic [PTR_W-1:0]        w_rd_id,    w_wr_id;
    logic                    w_rd_any,   w_wr_any;
    logic [INDEX_WIDTH-1:0]  w_raddr,    w_waddr;
    logic [ROW_W-1:0]        w_wdata,    w_resp_rdata;
    logic [NUM_ELEMENTS-1:0] w_wstrb;
    logic [NUM_REQ-1:0]      r_resp_oh;

    // Requests are masked in reset so no grant or bank strobe leaks out.
    assign w_rd_req = bus.req_valid & ~bus.req_wr & {NUM_REQ{nRST}};
    assign w_wr_req = bus.req_valid &  bus.req_wr & {NUM_REQ{nRST}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk(clk), .nRST(nRST), .i_req(w_rd_req),
        .o_grant(w_rd_grant), .o_id(w_rd_id), .o_any(w_rd_any)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk(clk), .nRST(nRST), .i_req(w_wr_req),
        .o_grant(w_wr_grant), .o_id(w_wr_id), .o_any(w_wr_any)
    );

    assign w_raddr = bus.req_addr[int'(w_rd_id)*INDEX_WIDTH +: INDEX_WIDTH];
    assign w_waddr = bus.req_addr[int'(w_wr_id)*INDEX_WIDTH +: INDEX_WIDTH];
    assign w_wdata = bus.req_wdata[int'(w_wr_id)*ROW_W +: ROW_W];
    assign w_wstrb = bus.req_wstrb[int'(w_wr_id)*NUM_ELEMENTS +: NUM_ELEMENTS];

    assign bus.req_ready = w_rd_grant | w_wr_grant;
    assign bus.ren       = w_rd_any;
    assign bus.raddr     = w_raddr;
    assign bus.wen       = w_wr_any;
    assign bus.waddr     = w_waddr;
    assign bus.wdata     = w_wdata;
    assign bus.wstrb     = w_wstrb;

    // One-hot read winner ID doubles as the response valid vector.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_resp_oh <= '0;
        end else begin
            r_resp_oh <= w_rd_grant;
        end
    end

`ifdef VBANK_ARB_RAW_FWD_EN
    logic                    r_fwd_hit;
    logic [ROW_W-1:0]        r_fwd_wdata;
    logic [NUM_ELEMENTS-1:0] r_fwd_wstrb;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_fwd_hit   <= 1'b0;
            r_fwd_wdata <= '0;
            r_fwd_wstrb <= '0;
        end else begin
            r_fwd_hit   <= w_rd_any && w_wr_any && (w_raddr == w_waddr);
            r_fwd_wdata <= w_wdata;
            r_fwd_wstrb <= w_wstrb;
        end
    end

    always_comb begin
        w_resp_rdata = bus.rdata;
        if (r_fwd_hit) begin
            for (int e = 0; e < NUM_ELEMENTS; e++) begin
                if (r_fwd_wstrb[e]) begin
                    w_resp_rdata[e*DATA_WIDTH +: DATA_WIDTH] = r_fwd_wdata[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
`else
    assign w_resp_rdata = bus.rdata;
`endif

    assign bus.resp_valid = r_resp_oh;
    assign bus.resp_rdata = w_resp_rdata;

endmodule : vbank_arb
`default_nettype wire

// File: tb/tb_vbank_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vbank_arb
// Description : Self-checking bench for vbank_arb with a behavioural bank and
//               reference model; directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vbank_arb;
    import vbank_pkg::*;

    localparam int N  = VB_NUM_REQ;
    localparam int IW = VB_INDEX_WIDTH;
    localparam int NE = VB_NUM_ELEMENTS;
    localparam int DW = VB_DATA_WIDTH;
    localparam int RW = NE * DW;

    logic clk;
    logic nRST;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    vbank_arb_if #(.NUM_REQ(N), .INDEX_WIDTH(IW), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW)) bus ();

    vbank_arb #(.NUM_REQ(N), .INDEX_WIDTH(IW), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW)) dut (
        .clk(clk), .nRST(nRST), .bus(bus)
    );

    // Bank: registered read of old contents, element-strobed write.
    logic [RW-1:0] mem [0:(1<<IW)-1];
    always @(posedge clk) begin
        if (bus.ren) bus.rdata <= mem[bus.raddr];
        if (bus.wen) begin
            for (int e = 0; e < NE; e++)
                if (bus.wstrb[e]) mem[bus.waddr][e*DW +: DW] <= bus.wdata[e*DW +: DW];
        end
    end

    // Reference model state
    logic [RW-1:0] gold [0:(1<<IW)-1];
    int            rd_ptr, wr_ptr, pend_id;
    bit            pend_vld;
    logic [RW-1:0] pend_data;

    vb_req_t       rq [N];
    logic [N-1:0]  vld;
    logic [N-1:0]  obs_ready, obs_resp_vld;
    logic [RW-1:0] obs_resp_data;
    int            n_chk, n_pass;

    task automatic chk(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [RW-1:0] merge(input logic [RW-1:0] old, input vb_req_t r);
        logic [RW-1:0] res;
        res = old;
        for (int e = 0; e < NE; e++)
            if (r.wstrb[e]) res[e*DW +: DW] = r.wdata[e*DW +: DW];
        return res;
    endfunction

    task automatic preload(input int row, input logic [RW-1:0] val);
        mem[row] <= val;
        gold[row] = val;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]               = vld[i];
            bus.req_wr[i]                  = rq[i].wr;
            bus.req_addr[i*IW +: IW]       = rq[i].addr;
            bus.req_wdata[i*RW +: RW]      = rq[i].wdata;
            bus.req_wstrb[i*NE +: NE]      = rq[i].wstrb;
        end
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < N; i++) begin
            vld[i]      = 1'($urandom_range(0, 1));
            rq[i].wr    = 1'($urandom_range(0, 1));
            rq[i].addr  = IW'($urandom_range(0, 7));
            for (int w = 0; w < RW / 32; w++) rq[i].wdata[w*32 +: 32] = $urandom;
            rq[i].wstrb = NE'($urandom);
        end
    endtask

    // One cycle: drive at negedge, check #1 later, advance model, wait next negedge.
    task automatic step();
        logic [N-1:0]  rv, wv, eoh, erdy;
        int            rw, ww;
        logic [RW-1:0] nd;
        drive();
        #1;
        if (!nRST) begin
            rd_ptr = 0; wr_ptr = 0; pend_vld = 0;
        end
        eoh = '0;
        if (pend_vld) eoh[pend_id] = 1'b1;
        chk("resp_valid", RW'(bus.resp_valid), RW'(eoh));
        if (pend_vld) chk("resp_rdata", bus.resp_rdata, pend_data);
        obs_ready     = bus.req_ready;
        obs_resp_vld  = bus.resp_valid;
        obs_resp_data = bus.resp_rdata;
        for (int i = 0; i < N; i++) begin
            rv[i] = vld[i] && !rq[i].wr && nRST;
            wv[i] = vld[i] &&  rq[i].wr && nRST;
        end
        rw = pick(rv, rd_ptr);
        ww = pick(wv, wr_ptr);
        erdy = '0;
        if (rw >= 0) erdy[rw] = 1'b1;
        if (ww >= 0) erdy[ww] = 1'b1;
        chk("req_ready", RW'(bus.req_ready), RW'(erdy));
        chk("ren", RW'(bus.ren), RW'(rw >= 0));
        chk("wen", RW'(bus.wen), RW'(ww >= 0));
        if (rw >= 0) chk("raddr", RW'(bus.raddr), RW'(rq[rw].addr));
        if (ww >= 0) begin
            chk("waddr", RW'(bus.waddr), RW'(rq[ww].addr));
            chk("wdata", bus.wdata, rq[ww].wdata);
            chk("wstrb", RW'(bus.wstrb), RW'(rq[ww].wstrb));
        end
        pend_vld = (rw >= 0);
        if (rw >= 0) begin
            pend_id = rw;
            nd      = gold[rq[rw].addr];
`ifdef VBANK_ARB_RAW_FWD_EN
            if (ww >= 0 && rq[ww].addr == rq[rw].addr) nd = merge(nd, rq[ww]);
`endif
            pend_data = nd;
            rd_ptr    = (rw + 1) % N;
        end
        if (ww >= 0) begin
            gold[rq[ww].addr] = merge(gold[rq[ww].addr], rq[ww]);
            wr_ptr = (ww + 1) % N;
        end
        @(negedge clk);
    endtask

    logic [RW-1:0] pat_a, pat_b, pat_c, pat_d, row9, exp37, tmp;

    initial begin
        n_chk = 0; n_pass = 0;
        rd_ptr = 0; wr_ptr = 0; pend_vld = 0; pend_id = 0; pend_data = '0;
        nRST = 1'b0;
        vld  = '0;
        for (int i = 0; i < N; i++) rq[i] = '0;
        for (int r = 0; r < (1 << IW); r++) begin
            for (int w = 0; w < RW / 32; w++) tmp[w*32 +: 32] = $urandom;
            preload(r, tmp);
        end
        for (int e = 0; e < NE; e++) begin
            pat_a[e*DW +: DW] = DW'(16'hA000 + e);
            pat_b[e*DW +: DW] = DW'(16'hB100 + e);
            pat_c[e*DW +: DW] = DW'(16'hC200 + e);
            pat_d[e*DW +: DW] = DW'(16'hD300 + e);
        end
        @(negedge clk);

        // Reset holds everything quiet even with requests present
        for (int c = 0; c < 2; c++) begin
            rand_reqs();
            vld = '1;
            step();
            chk("reset_ready", RW'(obs_ready), '0);
        end

        // Continuous reads from all requesters after release
        nRST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            vld = '1;
            for (int i = 0; i < N; i++) begin
                rq[i].wr = 1'b0; rq[i].addr = IW'(16 + i);
            end
            step();
            chk("rr_order", RW'(obs_ready), RW'(N'(1) << (c % N)));
        end

        // Single read, row 5
        preload(5, pat_a);
        vld = '0; vld[2] = 1'b1; rq[2].wr = 1'b0; rq[2].addr = 8'd5;
        step();
        chk("single_rd_ready", RW'(obs_ready), RW'(4'b0100));
        vld = '0;
        step();
        chk("single_rd_vld", RW'(obs_resp_vld), RW'(4'b0100));
        chk("single_rd_data", obs_resp_data, pat_a);

        // Concurrent read row 9 / write row 3, then read row 3
        row9 = gold[9];
        vld = 4'b0011;
        rq[0].wr = 1'b0; rq[0].addr = 8'd9;
        rq[1].wr = 1'b1; rq[1].addr = 8'd3; rq[1].wdata = pat_b; rq[1].wstrb = '1;
        step();
        chk("rw_both_ready", RW'(obs_ready), RW'(4'b0011));
        vld = 4'b0001; rq[0].addr = 8'd3;
        step();
        chk("rw_row9_data", obs_resp_data, row9);
        vld = '0;
        step();
        chk("wr_then_rd_data", obs_resp_data, pat_b);

        // Same-row read/write in the same cycle
        preload(7, pat_d);
        vld = 4'b0011;
        rq[0].wr = 1'b0; rq[0].addr = 8'd7;
        rq[1].wr = 1'b1; rq[1].addr = 8'd7; rq[1].wdata = pat_c; rq[1].wstrb = NE'(32'h0000FFFF);
        step();
        vld = '0;
        step();
        exp37 = pat_d;
`ifdef VBANK_ARB_RAW_FWD_EN
        exp37[16*DW-1:0] = pat_c[16*DW-1:0];
`endif
        chk("same_row_rw", obs_resp_data, exp37);

        // Reset right after a read grant drops the response
        vld = 4'b0001; rq[0].wr = 1'b0; rq[0].addr = 8'd2;
        step();
        nRST = 1'b0; vld = '0;
        step();
        chk("rst_drop_vld", RW'(obs_resp_vld), '0);
        step();
        nRST = 1'b1;
        vld = 4'b1000; rq[3].wr = 1'b0; rq[3].addr = 8'd4;
        step();
        chk("rst_release_grant", RW'(obs_ready), RW'(4'b1000));
        vld = '0;
        step();
        chk("rst_release_vld", RW'(obs_resp_vld), RW'(4'b1000));

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rand_reqs();
            nRST = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            step();
        end
        nRST = 1'b1; vld = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_vbank_arb
`default_nettype wire

// File: doc/vbank_arb.md
VBANK_ARB -- requirements
Module: vbank_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one vbank.
REQ-002 SHALL have parameter INDEX_WIDTH, default 8, row address width.
REQ-003 SHALL have parameter NUM_ELEMENTS, default 32, elements per row.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, bits per element.
REQ-005 SHALL have port clk  in  1  sole clock; all state rising-edge.
REQ-006 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester request valid.
REQ-008 SHALL have port req_ready  out  NUM_REQ  per-requester grant (accept this cycle).
REQ-009 SHALL have port req_wr  in  NUM_REQ  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  in  NUM_REQ*INDEX_WIDTH  flattened row addresses.
REQ-011 SHALL have port req_wdata  in  NUM_REQ*NUM_ELEMENTS*DATA_WIDTH  flattened write data.
REQ-012 SHALL have port req_wstrb  in  NUM_REQ*NUM_ELEMENTS  flattened element strobes.
REQ-013 SHALL have port resp_valid  out  NUM_REQ  one-hot read-response valid.
REQ-014 SHALL have port resp_rdata  out  NUM_ELEMENTS*DATA_WIDTH  shared read data.
REQ-015 SHALL have bank-side ports ren/raddr/wen/waddr/wdata/wstrb (out) and rdata (in), widths matching the vbank ports.

Function
REQ-016 SHALL arbitrate reads and writes independently: at most one read grant and one write grant per cycle.
REQ-017 SHALL use a separate round-robin pointer per class; search starts at pointer, pointer moves to winner+1 (mod NUM_REQ) only on a grant.
REQ-018 SHALL assert req_ready[i] combinationally in the cycle requester i wins; transfer = req_valid & req_ready.
REQ-019 SHALL drive ren=1, raddr=winner addr in the read-grant cycle; wen=1, waddr/wdata/wstrb=winner fields in the write-grant cycle; otherwise ren=wen=0.
REQ-020 SHALL register the read winner ID; resp_valid[id] SHALL assert exactly one cycle after the read grant, with resp_rdata = bank rdata.
REQ-021 Read latency SHALL be fixed at 1 cycle; no response backpressure; back-to-back reads SHALL yield back-to-back responses.
REQ-022 With no valid requests of a class, that pointer SHALL hold and no grant SHALL issue.
REQ-023 A requester SHALL never be starved: with continuous contention each of NUM_REQ requesters is granted once per NUM_REQ grants.
REQ-024 Write at cycle t then read of same row at t+1 SHALL return new data (no hazard logic required).
REQ-025 Same-row read and write granted in the same cycle: behaviour per REQ-030/031.

Reset
REQ-026 While nRST=0: both pointers = 0, resp_valid = 0, ren = wen = 0, req_ready = 0.
REQ-027 Reset asserted mid-operation SHALL drop any pending read response (no resp_valid after reset release).
REQ-028 First cycle after release SHALL grant normally from pointer 0.

Configuration
REQ-029 Macro VBANK_ARB_RAW_FWD_EN SHALL select same-cycle read/write forwarding.
REQ-030 Defined: on same-cycle same-row read and write grant, response SHALL return write data for elements with wstrb=1 and bank rdata elsewhere (registered wdata/wstrb/match flag, muxed at response cycle).
REQ-031 Undefined: response SHALL return pre-write bank data; no forwarding registers exist.

Structure
REQ-032 Shared package vbank_pkg SHALL hold default widths and a request struct typedef (wr, addr, wdata, wstrb).
REQ-033 One sub-module rr_arbiter (parameterised NUM_REQ, request vector in, one-hot grant out, pointer state inside) SHALL be instantiated twice (read, write).

Verification
REQ-034 Single read: req 2 reads row 5 holding pattern A -> ready[2] at t, resp_valid=4'b0100 and resp_rdata=A at t+1.
REQ-035 All 4 requesters read continuously from reset -> grant order 0,1,2,3,0,... one per cycle.
REQ-036 Req 1 writes row 3 (wstrb=all ones, data B) while req 0 reads row 9 same cycle -> both granted; read returns row-9 data; next-cycle read of row 3 returns B.
REQ-037 Same-cycle write row 7 (wstrb=0x0000FFFF, data C) and read row 7 (old D) -> with macro: low 16 elements C, upper D; without: all D.
REQ-038 nRST asserted the cycle after a read grant -> no resp_valid; after release, req 3 alone requesting is granted immediately.
